// File: rtl/vgaterm_writer.sv
// vgaterm_writer
// Feeds a text-mode VGA terminal from a byte stream. Each accepted byte is
// decoded into zero or more single-cell writes on the terminal's
// writereq/writeack four-phase handshake. A cursor is kept, and CR/LF/BS/FF
// are interpreted. A printable byte in the last column wraps to the next row.
// Every newly entered row is cleared, and FF clears the whole screen.
// Lower case can optionally be folded to upper case for a 64-glyph font.
//
// Ports
//   clk        system clock, all logic on posedge
//   rstn       synchronous reset, active low
//   datain     input byte, held by upstream until accepted
//   datavalid  datain valid
//   dataready  byte accepted on an edge where datavalid && dataready
//   xwrite     column of the current terminal write
//   ywrite     row of the current terminal write
//   charout    code of the current terminal write
//   writereq   write request to terminal
//   writeack   terminal acknowledge / busy
//   curx       cursor column
//   cury       cursor row
//   busy       high while any write or clear sequence is in progress
module vgaterm_writer #(
   parameter int         COLS   = 100,
   parameter int         ROWS   = 32,
   parameter int         XBITS  = 7,
   parameter int         YBITS  = 5,
   parameter logic [7:0] BLANK  = 8'h20,
   parameter bit         UPCASE = 1'b1
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic [7:0]       datain,
   input  logic             datavalid,
   output logic             dataready,
   output logic [XBITS-1:0] xwrite,
   output logic [YBITS-1:0] ywrite,
   output logic [7:0]       charout,
   output logic             writereq,
   input  logic             writeack,
   output logic [XBITS-1:0] curx,
   output logic [YBITS-1:0] cury,
   output logic             busy
);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_WAIT = 2'd2} state_t;
   typedef enum logic [1:0] {M_CHAR = 2'd0, M_NOADV = 2'd1, M_ROWCLR = 2'd2, M_SCRCLR = 2'd3} mode_t;

   localparam logic [XBITS-1:0] XMAX  = XBITS'(COLS - 1);
   localparam logic [YBITS-1:0] YMAX  = YBITS'(ROWS - 1);
   localparam logic [XBITS-1:0] XZERO = '0;
   localparam logic [XBITS-1:0] XONE  = XBITS'(1);
   localparam logic [YBITS-1:0] YZERO = '0;
   localparam logic [YBITS-1:0] YONE  = YBITS'(1);

   state_t           state_r;
   mode_t            mode_r;
   logic [XBITS-1:0] curx_r;
   logic [YBITS-1:0] cury_r;
   logic [XBITS-1:0] xwrite_r;
   logic [YBITS-1:0] ywrite_r;
   logic [7:0]       charout_r;
   logic             writereq_r;
   logic [7:0]       byte_s;
   logic             dataready_s;
   logic             accept_s;

   // Fold a..z onto A..Z when the font has no lower case glyphs.
   function automatic logic [7:0] fold_case(input logic [7:0] b);
      if (UPCASE && (b >= 8'h61) && (b <= 8'h7A)) begin
         return b - 8'h20;
      end else begin
         return b;
      end
   endfunction

   // Row increment wraps at ROWS, not at the register width.
   function automatic logic [YBITS-1:0] next_row(input logic [YBITS-1:0] y);
      if (y == YMAX) begin
         return YZERO;
      end else begin
         return y + YONE;
      end
   endfunction

   // Input acceptance and byte decode helpers.
   always_comb begin
      byte_s      = fold_case(datain);
      dataready_s = (state_r == S_IDLE) && !writeack && rstn;
      accept_s    = datavalid && dataready_s;
   end

   // Control FSM, cursor and registered write port.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_r    <= S_IDLE;
         mode_r     <= M_CHAR;
         curx_r     <= XZERO;
         cury_r     <= YZERO;
         xwrite_r   <= XZERO;
         ywrite_r   <= YZERO;
         charout_r  <= 8'h00;
         writereq_r <= 1'b0;
      end else begin
         case (state_r)
            S_IDLE: begin
               if (accept_s) begin
                  if ((byte_s >= 8'h20) && (byte_s <= 8'h7E)) begin
                     xwrite_r   <= curx_r;
                     ywrite_r   <= cury_r;
                     charout_r  <= byte_s;
                     mode_r     <= M_CHAR;
                     writereq_r <= 1'b1;
                     state_r    <= S_REQ;
                  end else begin
                     case (byte_s)
                        8'h0D: curx_r <= XZERO;
                        8'h0A: begin
                           curx_r     <= XZERO;
                           cury_r     <= next_row(cury_r);
                           xwrite_r   <= XZERO;
                           ywrite_r   <= next_row(cury_r);
                           charout_r  <= BLANK;
                           mode_r     <= M_ROWCLR;
                           writereq_r <= 1'b1;
                           state_r    <= S_REQ;
                        end
                        8'h08: begin
                           // Backspace at column 0 is a no-op.
                           if (curx_r != XZERO) begin
                              curx_r     <= curx_r - XONE;
                              xwrite_r   <= curx_r - XONE;
                              ywrite_r   <= cury_r;
                              charout_r  <= BLANK;
                              mode_r     <= M_NOADV;
                              writereq_r <= 1'b1;
                              state_r    <= S_REQ;
                           end else begin
                              curx_r <= curx_r;
                           end
                        end
                        8'h0C: begin
                           curx_r     <= XZERO;
                           cury_r     <= YZERO;
                           xwrite_r   <= XZERO;
                           ywrite_r   <= YZERO;
                           charout_r  <= BLANK;
                           mode_r     <= M_SCRCLR;
                           writereq_r <= 1'b1;
                           state_r    <= S_REQ;
                        end
                        default: state_r <= S_IDLE;
                     endcase
                  end
               end else begin
                  state_r <= S_IDLE;
               end
            end
            S_REQ: begin
               if (writeack) begin
                  writereq_r <= 1'b0;
                  state_r    <= S_WAIT;
               end else begin
                  writereq_r <= 1'b1;
               end
            end
            S_WAIT: begin
               // The cell is written once the terminal drops writeack.
               if (!writeack) begin
                  case (mode_r)
                     M_CHAR: begin
                        if (curx_r == XMAX) begin
                           curx_r     <= XZERO;
                           cury_r     <= next_row(cury_r);
                           xwrite_r   <= XZERO;
                           ywrite_r   <= next_row(cury_r);
                           charout_r  <= BLANK;
                           mode_r     <= M_ROWCLR;
                           writereq_r <= 1'b1;
                           state_r    <= S_REQ;
                        end else begin
                           curx_r  <= curx_r + XONE;
                           state_r <= S_IDLE;
                        end
                     end
                     M_ROWCLR: begin
                        if (xwrite_r == XMAX) begin
                           state_r <= S_IDLE;
                        end else begin
                           xwrite_r   <= xwrite_r + XONE;
                           writereq_r <= 1'b1;
                           state_r    <= S_REQ;
                        end
                     end
                     M_SCRCLR: begin
                        if ((xwrite_r == XMAX) && (ywrite_r == YMAX)) begin
                           state_r <= S_IDLE;
                        end else if (xwrite_r == XMAX) begin
                           xwrite_r   <= XZERO;
                           ywrite_r   <= ywrite_r + YONE;
                           writereq_r <= 1'b1;
                           state_r    <= S_REQ;
                        end else begin
                           xwrite_r   <= xwrite_r + XONE;
                           writereq_r <= 1'b1;
                           state_r    <= S_REQ;
                        end
                     end
                     default: state_r <= S_IDLE;
                  endcase
               end else begin
                  state_r <= S_WAIT;
               end
            end
            default: begin
               writereq_r <= 1'b0;
               state_r    <= S_IDLE;
            end
         endcase
      end
   end

   assign dataready = dataready_s;
   assign xwrite    = xwrite_r;
   assign ywrite    = ywrite_r;
   assign charout   = charout_r;
   assign writereq  = writereq_r;
   assign curx      = curx_r;
   assign cury      = cury_r;
   assign busy      = (state_r != S_IDLE);

endmodule

// File: tb/tb_vgaterm_writer.sv
module tb_vgaterm_writer;

   localparam int COLS = 100;
   localparam int ROWS = 32;

   logic       clk = 1'b0;
   logic       rstn;
   logic [7:0] datain;
   logic       datavalid;
   logic       dataready;
   logic [6:0] xwrite;
   logic [4:0] ywrite;
   logic [7:0] charout;
   logic       writereq;
   logic       writeack;
   logic [6:0] curx;
   logic [4:0] cury;
   logic       busy;

   logic [7:0] datain_b;
   logic       datavalid_b;
   logic       dataready_b;
   logic [6:0] xwrite_b;
   logic [4:0] ywrite_b;
   logic [7:0] charout_b;
   logic       writereq_b;
   logic       writeack_b;
   logic [6:0] curx_b;
   logic [4:0] cury_b;
   logic       busy_b;

   int total = 0;
   int bad   = 0;

   // terminal model state and scoreboards
   logic        hold = 1'b0;
   logic [19:0] cap_q[$];
   logic [19:0] exp_q[$];
   int          mx = 0;
   int          my = 0;

   always #5 clk = ~clk;

   vgaterm_writer dut (
      .clk(clk), .rstn(rstn), .datain(datain), .datavalid(datavalid), .dataready(dataready),
      .xwrite(xwrite), .ywrite(ywrite), .charout(charout), .writereq(writereq), .writeack(writeack),
      .curx(curx), .cury(cury), .busy(busy)
   );

   vgaterm_writer #(.UPCASE(1'b0)) dut_b (
      .clk(clk), .rstn(rstn), .datain(datain_b), .datavalid(datavalid_b), .dataready(dataready_b),
      .xwrite(xwrite_b), .ywrite(ywrite_b), .charout(charout_b), .writereq(writereq_b),
      .writeack(writeack_b), .curx(curx_b), .cury(cury_b), .busy(busy_b)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // terminal for the main DUT: random ack delays, records each cell at ack rise
   initial begin
      int cnt;
      cnt = 0;
      writeack = 1'b0;
      forever begin
         @(negedge clk);
         if (!writeack) begin
            if (writereq === 1'b1) begin
               if (cnt == 0) begin
                  writeack = 1'b1;
                  cap_q.push_back({xwrite, ywrite, charout});
                  cnt = $urandom_range(0, 1);
               end else begin
                  cnt--;
               end
            end
         end else if (writereq === 1'b0 && !hold) begin
            if (cnt == 0) begin
               writeack = 1'b0;
               cnt = $urandom_range(0, 1);
            end else begin
               cnt--;
            end
         end
      end
   end

   // trivial terminal for the UPCASE=0 instance
   initial begin
      writeack_b = 1'b0;
      forever begin
         @(negedge clk);
         writeack_b = (writereq_b === 1'b1);
      end
   end

   // handshake protocol monitor
   initial begin
      logic        prev_req;
      logic [19:0] lat;
      prev_req = 1'b0;
      lat = '0;
      forever begin
         @(posedge clk);
         #1;
         if (writereq === 1'b1 && !prev_req) begin
            chk("req_rise_while_ack", 32'(writeack), 32'd0);
            chk("ready_during_write", 32'(dataready), 32'd0);
            lat = {xwrite, ywrite, charout};
         end else if (writereq === 1'b1 && prev_req) begin
            chk("req_hold_stable", 32'({xwrite, ywrite, charout}), 32'(lat));
         end
         prev_req = (writereq === 1'b1);
      end
   end

   initial begin
      #1500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   function automatic void push_cell(input int x, input int y, input logic [7:0] c);
      exp_q.push_back({7'(x), 5'(y), c});
   endfunction

   // reference: expected writes and cursor from the byte rules
   function automatic void model_byte(input logic [7:0] b0);
      logic [7:0] b;
      b = b0;
      if (b >= 8'h61 && b <= 8'h7A) b = b - 8'h20;
      if (b >= 8'h20 && b <= 8'h7E) begin
         push_cell(mx, my, b);
         if (mx == COLS - 1) begin
            mx = 0;
            my = (my + 1) % ROWS;
            for (int c = 0; c < COLS; c++) push_cell(c, my, 8'h20);
         end else begin
            mx++;
         end
      end else if (b == 8'h0D) begin
         mx = 0;
      end else if (b == 8'h0A) begin
         mx = 0;
         my = (my + 1) % ROWS;
         for (int c = 0; c < COLS; c++) push_cell(c, my, 8'h20);
      end else if (b == 8'h08) begin
         if (mx > 0) begin
            mx--;
            push_cell(mx, my, 8'h20);
         end
      end else if (b == 8'h0C) begin
         mx = 0;
         my = 0;
         for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) push_cell(c, r, 8'h20);
      end
   endfunction

   task automatic send(input logic [7:0] b);
      logic ok;
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         #1;
         if (dataready) begin
            ok = 1'b1;
            break;
         end
      end
      chk("accept_timeout", 32'(ok), 32'd1);
      if (ok) begin
         datain = b;
         datavalid = 1'b1;
         @(posedge clk);
         #1;
         datavalid = 1'b0;
      end
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 40000; i++) begin
         if (busy === 1'b0) break;
         @(posedge clk);
         #1;
      end
      chk("idle_timeout", 32'(busy), 32'd0);
   endtask

   task automatic compare_all();
      chk("write_count", 32'(cap_q.size()), 32'(exp_q.size()));
      while (cap_q.size() > 0 && exp_q.size() > 0) begin
         chk("write_cell", 32'(cap_q.pop_front()), 32'(exp_q.pop_front()));
      end
      cap_q.delete();
      exp_q.delete();
      chk("curx", 32'(curx), 32'(mx));
      chk("cury", 32'(cury), 32'(my));
      chk("busy_idle", 32'(busy), 32'd0);
      chk("ready_idle", 32'(dataready), 32'd1);
   endtask

   task automatic do_byte(input logic [7:0] b);
      model_byte(b);
      send(b);
      wait_idle();
      compare_all();
   endtask

   task automatic goto_xy(input int x, input int y);
      do_byte(8'h0D);
      while (my != y) do_byte(8'h0A);
      for (int i = 0; i < x; i++) do_byte(8'h2E);
   endtask

   initial begin
      logic       ok;
      logic [7:0] rb;
      int         r;
      rstn = 1'b0;
      datain = 8'h00;
      datavalid = 1'b0;
      datain_b = 8'h00;
      datavalid_b = 1'b0;

      // reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_writereq", 32'(writereq), 32'd0);
      chk("rst_cursor", 32'({curx, cury}), 32'd0);
      chk("rst_port", 32'({xwrite, ywrite, charout}), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_ready", 32'(dataready), 32'd0);
      @(negedge clk);
      rstn = 1'b1;

      // single char, then case folding on both instances
      do_byte(8'h41);
      do_byte(8'h61);
      @(negedge clk);
      #1;
      chk("b_ready", 32'(dataready_b), 32'd1);
      datain_b = 8'h61;
      datavalid_b = 1'b1;
      @(posedge clk);
      #1;
      datavalid_b = 1'b0;
      chk("b_writereq", 32'(writereq_b), 32'd1);
      chk("b_charout_nofold", 32'(charout_b), 32'h61);

      // wrap at last column clears the next row
      goto_xy(99, 5);
      do_byte(8'h42);
      chk("wrap_cursor", 32'({curx, cury}), 32'({7'd0, 5'd6}));

      // LF on last row wraps to row 0; CR without a write
      goto_xy(7, 31);
      do_byte(8'h0A);
      chk("lf_wrap_cursor", 32'({curx, cury}), 32'd0);
      goto_xy(9, 0);
      do_byte(8'h0D);

      // backspace edges and dropped control byte
      do_byte(8'h08);
      goto_xy(3, 2);
      do_byte(8'h08);
      chk("bs_cursor", 32'({curx, cury}), 32'({7'd2, 5'd2}));
      do_byte(8'h07);

      // randomized stream
      for (int n = 0; n < 150; n++) begin
         r = $urandom_range(0, 99);
         if (r < 70) rb = 8'($urandom_range(32, 126));
         else if (r < 77) rb = 8'h0D;
         else if (r < 83) rb = 8'h0A;
         else if (r < 91) rb = 8'h08;
         else begin
            rb = 8'($urandom_range(0, 255));
            if (rb == 8'h0C) rb = 8'h07;
         end
         do_byte(rb);
      end

      // full screen clear
      do_byte(8'h0C);

      // reset in the middle of a clear while the terminal holds writeack
      model_byte(8'h0C);
      send(8'h0C);
      ok = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         #1;
         if (writereq && writeack && cap_q.size() > 5) begin
            ok = 1'b1;
            break;
         end
      end
      chk("midwrite_found", 32'(ok), 32'd1);
      hold = 1'b1;
      rstn = 1'b0;
      @(posedge clk);
      #1;
      chk("mid_rst_writereq", 32'(writereq), 32'd0);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_ready", 32'(dataready), 32'd0);
      chk("mid_rst_cursor", 32'({curx, cury}), 32'd0);
      @(negedge clk);
      rstn = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         chk("ready_blocked_by_ack", 32'(dataready), 32'd0);
      end
      hold = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         #1;
         if (dataready) begin
            ok = 1'b1;
            break;
         end
      end
      chk("ready_after_ack_low", 32'(ok), 32'd1);
      cap_q.delete();
      exp_q.delete();
      mx = 0;
      my = 0;
      do_byte(8'h5A);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
